regbank_writeback: RTL and testbench
====================================

// Module: regbank_writeback
// PURPOSE
//  Write-side front end for the 32x32 register bank. Collects writeback requests from
//  the ALU and load/memory producers over valid/ready and buffers them in a FIFO.
//  Drains one entry per cycle onto the bank's single write port (regC/dataWrite/writeFlag).
//  Exposes forwarding lookups so operand fetch sees values still in flight.
// PARAMETERS
//  DATA_W   32  register data width
//  ADDR_W   5   register index width (2**ADDR_W registers)
//  DEPTH    4   FIFO entries; power of 2, >= 2
// PORTS
//  clock         in   1       rising-edge clock
//  reset_n       in   1       asynchronous active-low reset
//  aluValid      in   1       ALU writeback request valid
//  aluReady      out  1       ALU request accepted this cycle (comb.)
//  aluReg        in   ADDR_W  ALU destination register
//  aluData       in   DATA_W  ALU result
//  memValid      in   1       memory writeback request valid
//  memReady      out  1       memory request accepted this cycle (comb.)
//  memReg        in   ADDR_W  load destination register
//  memData       in   DATA_W  load data
//  bankBusy      in   1       1 = hold drain (bank write port unavailable)
//  regC          out  ADDR_W  bank write index (registered)
//  dataWrite     out  DATA_W  bank write data (registered)
//  writeFlag     out  1       bank write enable (registered)
//  lookupRegA    in   ADDR_W  operand A index to check
//  lookupRegB    in   ADDR_W  operand B index to check
//  hitA/hitB     out  1       pending write exists for lookupRegA/B (comb.)
//  fwdDataA/B    out  DATA_W  youngest pending data for A/B; 0 when no hit
//  pendingCount  out  $clog2(DEPTH)+1  entries in FIFO (excl. output reg)
// BEHAVIOUR
//  - Reset (async, reset_n=0): FIFO empty, pointers 0, writeFlag=0, regC=0, dataWrite=0,
//    pendingCount=0, arbiter last-grant = ALU. Entries in flight are discarded.
//  - Accept: at most one request per cycle. Space = (count<DEPTH) | pop this cycle.
//    Granted ready = valid & space. Transfer occurs when valid & ready at the clock edge.
//  - Arbitration (both valid): memory wins (see CONFIGURATION).
//  - Register 0: request with Reg==0 is accepted (ready=1 if granted) but not enqueued.
//  - Drain: pop when count>0 & !bankBusy; head loads regC/dataWrite, writeFlag=1 next cycle.
//    If no pop, writeFlag=0 next cycle and regC/dataWrite hold their last values.
//  - Latency: request accepted at edge k -> writeFlag=1 after edge k+1 at the earliest.
//  - Simultaneous push+pop with count==DEPTH: allowed; count unchanged.
//    Push into empty FIFO and pop the same cycle: not allowed (entry pops next edge).
//  - Pointers wrap modulo DEPTH; count saturates via ready, never exceeds DEPTH.
//  - Forwarding: compare lookupReg against all valid FIFO entries plus the output register
//    while writeFlag=1. The youngest match wins: FIFO tail-most, then output reg.
//    Index 0 never hits. Incoming same-cycle requests are not forwarded.
//  - Ordering: writes to the bank occur strictly in acceptance order.
// CONFIGURATION
//  WB_ROUND_ROBIN_EN defined: when both valid, grant alternates. The source not granted
//    last time wins; last-grant updates only on an actual transfer.
//  WB_ROUND_ROBIN_EN undefined: fixed priority, memory over ALU; last-grant unused.
// TESTING
//  1. Reset mid-drain with 3 entries queued -> writeFlag=0, pendingCount=0 same cycle;
//     no bank write after release.
//  2. ALU r5=0x11 at edge 1 -> writeFlag=1, regC=5, dataWrite=0x11 after edge 2 only.
//  3. bankBusy=1, push r1..r4 -> 5th push sees aluReady=0. Release bankBusy -> bank
//     writes r1,r2,r3,r4 in order; a held push is accepted the same cycle as the first pop.
//  4. Both valid every cycle (mem r7/0xA.., alu r8/0xB..), no macro -> only mem accepted.
//     With WB_ROUND_ROBIN_EN -> grants alternate mem,alu,mem,alu.
//  5. Queue r3=0x1 then r3=0x2, lookupRegA=3 -> hitA=1, fwdDataA=0x2. lookupRegB=0
//     while r0 pushed -> hitB=0, no write, pendingCount unchanged.
//  6. Full FIFO with pop and push same edge -> pendingCount stays DEPTH; the new entry
//     drains last.

Source files
------------

// File: rtl/regbank_writeback_if.sv
// Writeback request, bank write port and forwarding lookup bundle for regbank_writeback.
// slave = writeback block side, master = producers/bank/operand-fetch side.
interface regbank_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              aluValid;
  logic              aluReady;
  logic [ADDR_W-1:0] aluReg;
  logic [DATA_W-1:0] aluData;
  logic              memValid;
  logic              memReady;
  logic [ADDR_W-1:0] memReg;
  logic [DATA_W-1:0] memData;
  logic              bankBusy;
  logic [ADDR_W-1:0] regC;
  logic [DATA_W-1:0] dataWrite;
  logic              writeFlag;
  logic [ADDR_W-1:0] lookupRegA;
  logic [ADDR_W-1:0] lookupRegB;
  logic              hitA;
  logic              hitB;
  logic [DATA_W-1:0] fwdDataA;
  logic [DATA_W-1:0] fwdDataB;
  logic [CNT_W-1:0]  pendingCount;

  modport slave (
    input  aluValid, aluReg, aluData,
    input  memValid, memReg, memData,
    input  bankBusy, lookupRegA, lookupRegB,
    output aluReady, memReady,
    output regC, dataWrite, writeFlag,
    output hitA, hitB, fwdDataA, fwdDataB, pendingCount
  );

  modport master (
    output aluValid, aluReg, aluData,
    output memValid, memReg, memData,
    output bankBusy, lookupRegA, lookupRegB,
    input  aluReady, memReady,
    input  regC, dataWrite, writeFlag,
    input  hitA, hitB, fwdDataA, fwdDataB, pendingCount
  );
endinterface

// File: rtl/regbank_writeback.sv
// Buffers ALU/memory writebacks in a FIFO and drains one per cycle to the register bank write port.
// Latency: accepted at edge k -> writeFlag after edge k+1; ready drops when full and not popping, drain holds on bankBusy.
// WB_ROUND_ROBIN_EN selects alternating ALU/memory grant; default is fixed memory-over-ALU priority.
module regbank_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  regbank_writeback_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] ent_reg_q [DEPTH];
  logic [DATA_W-1:0] ent_dat_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] regc_q, regc_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              wflag_q, wflag_d;

  logic              pop;
  logic              space;
  logic              mem_gnt, alu_gnt;
  logic              mem_xfer, alu_xfer;
  logic              push;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_dat;

  assign pop   = (count_q != '0) && !bus.bankBusy;
  assign space = (count_q < CNT_W'(DEPTH)) || pop;

`ifdef WB_ROUND_ROBIN_EN
  logic last_mem_q, last_mem_d;

  // On contention the source that did not win the last transfer goes first.
  assign mem_gnt    = bus.memValid && (!bus.aluValid || !last_mem_q);
  assign alu_gnt    = bus.aluValid && !mem_gnt;
  assign last_mem_d = mem_xfer ? 1'b1 : (alu_xfer ? 1'b0 : last_mem_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_mem_q <= 1'b0;
    end else begin
      last_mem_q <= last_mem_d;
    end
  end
`else
  assign mem_gnt = bus.memValid;
  assign alu_gnt = bus.aluValid && !bus.memValid;
`endif

  // r0 writes are swallowed, so they never need FIFO space.
  assign bus.memReady = mem_gnt && (space || (bus.memReg == '0));
  assign bus.aluReady = alu_gnt && (space || (bus.aluReg == '0));

  assign mem_xfer = bus.memValid && bus.memReady;
  assign alu_xfer = bus.aluValid && bus.aluReady;
  assign in_reg   = mem_xfer ? bus.memReg  : bus.aluReg;
  assign in_dat   = mem_xfer ? bus.memData : bus.aluData;
  assign push     = (mem_xfer || alu_xfer) && (in_reg != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    regc_d   = regc_q;
    wdat_d   = wdat_q;
    wflag_d  = 1'b0;
    if (pop) begin
      regc_d  = ent_reg_q[rd_ptr_q];
      wdat_d  = ent_dat_q[rd_ptr_q];
      wflag_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      regc_q   <= '0;
      wdat_q   <= '0;
      wflag_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      regc_q   <= regc_d;
      wdat_q   <= wdat_d;
      wflag_q  <= wflag_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg_q[i] <= '0;
        ent_dat_q[i] <= '0;
      end
    end else if (push) begin
      ent_reg_q[wr_ptr_q] <= in_reg;
      ent_dat_q[wr_ptr_q] <= in_dat;
    end
  end

  // Scan oldest to youngest (output reg, then FIFO head..tail) so the last match wins.
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    if (wflag_q) begin
      if ((bus.lookupRegA != '0) && (regc_q == bus.lookupRegA)) begin
        hit_a = 1'b1;
        fwd_a = wdat_q;
      end
      if ((bus.lookupRegB != '0) && (regc_q == bus.lookupRegB)) begin
        hit_b = 1'b1;
        fwd_b = wdat_q;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_q) begin
        if ((bus.lookupRegA != '0) &&
            (ent_reg_q[rd_ptr_q + PTR_W'(k)] == bus.lookupRegA)) begin
          hit_a = 1'b1;
          fwd_a = ent_dat_q[rd_ptr_q + PTR_W'(k)];
        end
        if ((bus.lookupRegB != '0) &&
            (ent_reg_q[rd_ptr_q + PTR_W'(k)] == bus.lookupRegB)) begin
          hit_b = 1'b1;
          fwd_b = ent_dat_q[rd_ptr_q + PTR_W'(k)];
        end
      end
    end
  end

  assign bus.hitA         = hit_a;
  assign bus.hitB         = hit_b;
  assign bus.fwdDataA     = fwd_a;
  assign bus.fwdDataB     = fwd_b;
  assign bus.regC         = regc_q;
  assign bus.dataWrite    = wdat_q;
  assign bus.writeFlag    = wflag_q;
  assign bus.pendingCount = count_q;
endmodule

// File: tb/tb_regbank_writeback.sv
// Directed bench for regbank_writeback: reset, latency, full/backpressure, arbitration, forwarding, r0 drop.
module tb_regbank_writeback;
  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  regbank_writeback_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) bus ();

  regbank_writeback #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.aluValid = 1'b0;
    bus.aluReg   = '0;
    bus.aluData  = '0;
    bus.memValid = 1'b0;
    bus.memReg   = '0;
    bus.memData  = '0;
  endtask

  task automatic push_alu(input logic [4:0] r, input logic [31:0] d);
    bus.aluValid = 1'b1;
    bus.aluReg   = r;
    bus.aluData  = d;
  endtask

  logic [31:0] exp_r [4];
  logic [31:0] exp_d [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    idle();
    bus.bankBusy   = 1'b0;
    bus.lookupRegA = '0;
    bus.lookupRegB = '0;
    #2;
    check("rst_wflag", 32'(bus.writeFlag), 32'd0);
    check("rst_count", 32'(bus.pendingCount), 32'd0);
    check("rst_regc", 32'(bus.regC), 32'd0);
    check("rst_data", bus.dataWrite, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Latency: r5=0x11 accepted at edge k, visible on the bank port after edge k+1.
    push_alu(5'd5, 32'h11);
    #1 check("lat_rdy", 32'(bus.aluReady), 32'd1);
    step();
    idle();
    bus.lookupRegA = 5'd5;
    #1;
    check("lat_wflag_k", 32'(bus.writeFlag), 32'd0);
    check("lat_count_k", 32'(bus.pendingCount), 32'd1);
    check("lat_fifo_hit", 32'(bus.hitA), 32'd1);
    check("lat_fifo_fwd", bus.fwdDataA, 32'h11);
    step();
    check("lat_wflag", 32'(bus.writeFlag), 32'd1);
    check("lat_regc", 32'(bus.regC), 32'd5);
    check("lat_data", bus.dataWrite, 32'h11);
    check("lat_count", 32'(bus.pendingCount), 32'd0);
    check("lat_out_fwd", bus.fwdDataA, 32'h11);
    step();
    check("lat_wflag_off", 32'(bus.writeFlag), 32'd0);
    check("lat_regc_hold", 32'(bus.regC), 32'd5);
    check("lat_hit_off", 32'(bus.hitA), 32'd0);
    check("lat_fwd_zero", bus.fwdDataA, 32'd0);

    // Fill under bankBusy, then a held push lands on the first pop edge and drains last.
    bus.bankBusy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_alu(5'(i), 32'h100 + 32'(i));
      #1 check("fill_rdy", 32'(bus.aluReady), 32'd1);
      step();
    end
    push_alu(5'd9, 32'h99);
    #1;
    check("full_rdy", 32'(bus.aluReady), 32'd0);
    check("full_count", 32'(bus.pendingCount), 32'd4);
    step();
    check("full_hold_rdy", 32'(bus.aluReady), 32'd0);
    check("full_hold_count", 32'(bus.pendingCount), 32'd4);
    bus.bankBusy = 1'b0;
    #1 check("full_pop_rdy", 32'(bus.aluReady), 32'd1);
    step();
    idle();
    #1;
    check("pp_count", 32'(bus.pendingCount), 32'd4);
    check("pp_wflag", 32'(bus.writeFlag), 32'd1);
    check("pp_regc", 32'(bus.regC), 32'd1);
    check("pp_data", bus.dataWrite, 32'h101);
    exp_r[0] = 32'd2;   exp_r[1] = 32'd3;   exp_r[2] = 32'd4;   exp_r[3] = 32'd9;
    exp_d[0] = 32'h102; exp_d[1] = 32'h103; exp_d[2] = 32'h104; exp_d[3] = 32'h99;
    for (int j = 0; j < 4; j++) begin
      step();
      check("order_wflag", 32'(bus.writeFlag), 32'd1);
      check("order_regc", 32'(bus.regC), exp_r[j]);
      check("order_data", bus.dataWrite, exp_d[j]);
      check("order_count", 32'(bus.pendingCount), 32'(3 - j));
    end
    step();
    check("order_idle", 32'(bus.writeFlag), 32'd0);

    // Forwarding picks the youngest r3; r0 is accepted but never queued or written.
    bus.bankBusy = 1'b1;
    push_alu(5'd3, 32'h1);
    step();
    push_alu(5'd3, 32'h2);
    step();
    idle();
    bus.lookupRegA = 5'd3;
    #1;
    check("fwd_hitA", 32'(bus.hitA), 32'd1);
    check("fwd_dataA", bus.fwdDataA, 32'h2);
    push_alu(5'd0, 32'hDEAD);
    bus.lookupRegB = 5'd0;
    #1;
    check("r0_rdy", 32'(bus.aluReady), 32'd1);
    check("r0_hitB", 32'(bus.hitB), 32'd0);
    check("r0_fwdB", bus.fwdDataB, 32'd0);
    step();
    idle();
    bus.lookupRegB = 5'd4;
    #1;
    check("r0_count", 32'(bus.pendingCount), 32'd2);
    check("miss_hitB", 32'(bus.hitB), 32'd0);
    bus.bankBusy = 1'b0;
    step();
    check("fwd_d1_regc", 32'(bus.regC), 32'd3);
    check("fwd_d1_data", bus.dataWrite, 32'h1);
    check("fwd_d1_young", bus.fwdDataA, 32'h2);
    step();
    check("fwd_d2_data", bus.dataWrite, 32'h2);
    check("fwd_d2_out", bus.fwdDataA, 32'h2);
    check("fwd_d2_count", 32'(bus.pendingCount), 32'd0);
    step();
    check("r0_no_write", 32'(bus.writeFlag), 32'd0);
    check("fwd_gone", 32'(bus.hitA), 32'd0);

    // Contention: mem r7/0xA<i> against alu r8/0xB<i> every cycle.
    bus.bankBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.memValid = 1'b1;
      bus.memReg   = 5'd7;
      bus.memData  = 32'hA0 + 32'(i);
      push_alu(5'd8, 32'hB0 + 32'(i));
      #1;
`ifdef WB_ROUND_ROBIN_EN
      check("arb_mem", 32'(bus.memReady), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("arb_alu", 32'(bus.aluReady), (i % 2 == 0) ? 32'd0 : 32'd1);
      exp_r[i] = (i % 2 == 0) ? 32'd7 : 32'd8;
      exp_d[i] = (i % 2 == 0) ? 32'hA0 + 32'(i) : 32'hB0 + 32'(i);
`else
      check("arb_mem", 32'(bus.memReady), 32'd1);
      check("arb_alu", 32'(bus.aluReady), 32'd0);
      exp_r[i] = 32'd7;
      exp_d[i] = 32'hA0 + 32'(i);
`endif
      step();
    end
    idle();
    bus.bankBusy = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      check("arb_regc", 32'(bus.regC), exp_r[j]);
      check("arb_data", bus.dataWrite, exp_d[j]);
    end

    // Reset mid-drain with three entries queued.
    bus.bankBusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_alu(5'(10 + i), 32'hC0 + 32'(i));
      step();
    end
    idle();
    #1 check("mid_count", 32'(bus.pendingCount), 32'd3);
    bus.bankBusy = 1'b0;
    step();
    check("mid_wflag", 32'(bus.writeFlag), 32'd1);
    check("mid_regc", 32'(bus.regC), 32'd10);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_wflag", 32'(bus.writeFlag), 32'd0);
    check("mid_rst_count", 32'(bus.pendingCount), 32'd0);
    check("mid_rst_regc", 32'(bus.regC), 32'd0);
    step();
    reset_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      check("post_rst_wflag", 32'(bus.writeFlag), 32'd0);
      check("post_rst_count", 32'(bus.pendingCount), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
